// File: rtl/pe_array_ctrl.sv
// Output-stationary loop-nest sequencer for pe_array: m outer, row tile j middle, reduction i inner.
// Optional busy-cycle counter on perf_cycles when PE_CTRL_PERF_CNT_EN is defined.
module pe_array_ctrl #(
  parameter int MAC_NUM = 4,
  parameter int IA_H    = 8,
  parameter int IA_W    = 8,
  parameter int OA_W    = 8,
  parameter int RW      = (IA_H > 1) ? $clog2(IA_H) : 1,
  parameter int CW      = (IA_W > 1) ? $clog2(IA_W) : 1,
  parameter int MW      = (OA_W > 1) ? $clog2(OA_W) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    cfg_shift_num,
  output logic          busy,
  output logic          done,
  output logic          act_rd_en,
  output logic [RW-1:0] act_rd_row,
  output logic [CW-1:0] act_rd_col,
  output logic          wet_rd_en,
  output logic [CW-1:0] wet_rd_row,
  output logic [MW-1:0] wet_rd_col,
  output logic          pe_mac_enable,
  output logic          pe_clear_acc,
  output logic [7:0]    pe_res_shift_num,
  output logic          out_wr_en,
  output logic [RW-1:0] out_wr_row,
  output logic [MW-1:0] out_wr_col,
  output logic [31:0]   perf_cycles
);

  localparam logic [CW-1:0] I_LAST   = CW'(IA_W - 1);
  localparam logic [RW-1:0] ROW_STEP = RW'(MAC_NUM);
  localparam logic [RW-1:0] ROW_LAST = RW'(IA_H - MAC_NUM);
  localparam logic [MW-1:0] M_LAST   = MW'(OA_W - 1);

  typedef enum logic [2:0] {IDLE, FEED, LAST, CLEAR, WAIT, WRITE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] i_reg, i_next;
  logic [RW-1:0] row_reg, row_next;
  logic [MW-1:0] m_reg, m_next;
  logic          mac_en_reg;
  logic [7:0]    shift_reg;
  logic          done_reg;
  logic          start_acc;
  logic          last_i, last_row, last_col;

  assign start_acc = (state_reg == IDLE) && start;
  assign last_i    = (i_reg == I_LAST);
  assign last_row  = (row_reg == ROW_LAST);
  assign last_col  = (m_reg == M_LAST);

  // State register and loop counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      row_reg   <= '0;
      m_reg     <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      row_reg   <= row_next;
      m_reg     <= m_next;
    end
  end

  // Next-state and loop-nest advance
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    row_next   = row_reg;
    m_next     = m_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FEED;
          i_next     = '0;
          row_next   = '0;
          m_next     = '0;
        end
      end
      FEED: begin
        if (last_i) begin
          state_next = LAST;
        end else begin
          i_next = i_reg + 1'b1;
        end
      end
      LAST:  state_next = CLEAR;
      CLEAR: state_next = WAIT;
      WAIT:  state_next = WRITE;
      WRITE: begin
        i_next = '0;
        if (last_row) begin
          row_next = '0;
          m_next   = last_col ? '0 : m_reg + 1'b1;
        end else begin
          row_next = row_reg + ROW_STEP;
        end
        state_next = (last_row && last_col) ? IDLE : FEED;
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs; addresses are forced to zero whenever their strobe is low
  always_comb begin
    busy         = (state_reg != IDLE);
    act_rd_en    = (state_reg == FEED);
    wet_rd_en    = act_rd_en;
    act_rd_row   = act_rd_en ? row_reg : '0;
    act_rd_col   = act_rd_en ? i_reg   : '0;
    wet_rd_row   = act_rd_en ? i_reg   : '0;
    wet_rd_col   = act_rd_en ? m_reg   : '0;
    pe_clear_acc = (state_reg == CLEAR);
    out_wr_en    = (state_reg == WRITE);
    out_wr_row   = out_wr_en ? row_reg : '0;
    out_wr_col   = out_wr_en ? m_reg   : '0;
  end

  // MAC enable trails the read strobe by the buffer read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_en_reg <= 1'b0;
      shift_reg  <= '0;
      done_reg   <= 1'b0;
    end else begin
      mac_en_reg <= (state_reg == FEED);
      if (start_acc) begin
        shift_reg <= cfg_shift_num;
      end
      done_reg <= (state_reg == WRITE) && last_row && last_col;
    end
  end

  assign pe_mac_enable    = mac_en_reg;
  assign pe_res_shift_num = shift_reg;
  assign done             = done_reg;

`ifdef PE_CTRL_PERF_CNT_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reg <= '0;
    end else if (start_acc) begin
      perf_reg <= '0;
    end else if (busy) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign perf_cycles = perf_reg;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed self-checking bench for pe_array_ctrl: full runs, back-to-back start,
// ignored start during FEED, and reset abort during CLEAR.
module tb_pe_array_ctrl;

  localparam int TILES     = 16;
  localparam int BUSY_EXP  = 192;
`ifdef PE_CTRL_PERF_CNT_EN
  localparam int PERF_EXP  = 192;
`else
  localparam int PERF_EXP  = 0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  cfg_shift_num;
  logic        busy;
  logic        done;
  logic        act_rd_en;
  logic [2:0]  act_rd_row;
  logic [2:0]  act_rd_col;
  logic        wet_rd_en;
  logic [2:0]  wet_rd_row;
  logic [2:0]  wet_rd_col;
  logic        pe_mac_enable;
  logic        pe_clear_acc;
  logic [7:0]  pe_res_shift_num;
  logic        out_wr_en;
  logic [2:0]  out_wr_row;
  logic [2:0]  out_wr_col;
  logic [31:0] perf_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pe_array_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cfg_shift_num    (cfg_shift_num),
    .busy             (busy),
    .done             (done),
    .act_rd_en        (act_rd_en),
    .act_rd_row       (act_rd_row),
    .act_rd_col       (act_rd_col),
    .wet_rd_en        (wet_rd_en),
    .wet_rd_row       (wet_rd_row),
    .wet_rd_col       (wet_rd_col),
    .pe_mac_enable    (pe_mac_enable),
    .pe_clear_acc     (pe_clear_acc),
    .pe_res_shift_num (pe_res_shift_num),
    .out_wr_en        (out_wr_en),
    .out_wr_row       (out_wr_row),
    .out_wr_col       (out_wr_col),
    .perf_cycles      (perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_rd"},    {act_rd_en, wet_rd_en, act_rd_row, act_rd_col, wet_rd_row, wet_rd_col}, 0);
    check({tag, "_pe"},    {pe_mac_enable, pe_clear_acc}, 0);
    check({tag, "_shift"}, pe_res_shift_num, 0);
    check({tag, "_wr"},    {out_wr_en, out_wr_row, out_wr_col}, 0);
    check({tag, "_perf"},  perf_cycles, 0);
  endtask

  // mode 0: plain run; mode 1: extra start pulse during FEED of tile 3;
  // mode 2: reset asserted during CLEAR of tile 5 (returns with reset held high)
  task automatic run_job(input logic [7:0] cfg, input int mode);
    int busy_cnt = 0;
    int wr_cnt   = 0;
    int mac_cnt  = 0;
    int exp_i    = 0;
    bit clr_d1   = 0;
    bit clr_d2   = 0;
    bit injected = 0;
    bit finished = 0;
    start         = 1'b1;
    cfg_shift_num = cfg;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      start = 1'b0;
      if (done) begin
        finished = 1;
        check("busy_in_done", busy, 0);
      end else begin
        busy_cnt += int'(busy);
        check("wet_en", wet_rd_en, act_rd_en);
        if (act_rd_en) begin
          check("act_row", act_rd_row, (wr_cnt % 2) * 4);
          check("act_col", act_rd_col, exp_i);
          check("wet_row", wet_rd_row, exp_i);
          check("wet_col", wet_rd_col, wr_cnt / 2);
          exp_i++;
        end else begin
          check("rd_addr_zero", {act_rd_row, act_rd_col, wet_rd_row, wet_rd_col}, 0);
        end
        if (pe_mac_enable) mac_cnt++;
        if (out_wr_en) begin
          $display("write %0d: row=%0d col=%0d shift=%0d", wr_cnt, out_wr_row, out_wr_col, pe_res_shift_num);
          check("wr_row", out_wr_row, (wr_cnt % 2) * 4);
          check("wr_col", out_wr_col, wr_cnt / 2);
          check("clear_2_before_wr", clr_d2, 1);
          check("mac_per_tile", mac_cnt, 8);
          check("feed_len", exp_i, 8);
          check("shift_num", pe_res_shift_num, cfg);
          wr_cnt++;
          mac_cnt = 0;
          exp_i   = 0;
        end else begin
          check("wr_addr_zero", {out_wr_row, out_wr_col}, 0);
        end
        if (mode == 1 && !injected && wr_cnt == 2 && act_rd_en && act_rd_col == 3'd2) begin
          start         = 1'b1;
          cfg_shift_num = 8'hA5;
          injected      = 1;
        end
        if (mode == 2 && wr_cnt == 4 && pe_clear_acc) begin
          reset = 1'b1;
          #1;
          check_all_zero("abort");
          return;
        end
        clr_d2 = clr_d1;
        clr_d1 = pe_clear_acc;
        tick();
      end
    end
    $display("run cfg=%0d mode=%0d: busy=%0d writes=%0d perf=%0d done=%0d",
             cfg, mode, busy_cnt, wr_cnt, perf_cycles, finished);
    check("done_seen", finished, 1);
    check("busy_cycles", busy_cnt, BUSY_EXP);
    check("write_count", wr_cnt, TILES);
    check("perf_cycles", perf_cycles, PERF_EXP);
    check("shift_after_done", pe_res_shift_num, cfg);
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    cfg_shift_num = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("reset");

    // Full run; the next run is launched from the done cycle itself
    run_job(8'd8, 0);
    run_job(8'd3, 1);
    tick();
    check("done_single_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("shift_hold", pe_res_shift_num, 3);
    check("perf_hold", perf_cycles, PERF_EXP);

    // Abort mid-run, then restart from a clean loop nest
    run_job(8'd6, 2);
    tick();
    check_all_zero("reset_held");
    reset = 1'b0;
    tick();
    tick();
    check("post_reset_idle", busy, 0);
    run_job(8'd5, 0);
    tick();
    check("final_done_low", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
